// File: rtl/crosshair_sprite_gen.sv
// Crosshair sprite compositor: generates colour-LUT addresses from the scan position,
// aligns background with the 1-cycle LUT read and applies chroma-key transparency.
module crosshair_sprite_gen #(
  parameter int                    SPR_BITS   = 5,
  parameter int                    COORD_W    = 11,
  parameter int                    DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = '0,
  localparam int                   ADDR_WIDTH = 2*SPR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  input  logic [DATA_WIDTH-1:0] bg_rgb,
  input  logic                  frame_start,
  input  logic                  wr_pos,
  input  logic [COORD_W-1:0]    pos_x_in,
  input  logic [COORD_W-1:0]    pos_y_in,
  input  logic                  en_in,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_data,
  output logic [DATA_WIDTH-1:0] rgb_out,
  output logic                  sprite_hit
);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pos_t;

  localparam logic [COORD_W:0] SIDE = (COORD_W+1)'(2**SPR_BITS);

  pos_t act, pend, pos_in;
  logic pend_valid;

  assign pos_in = {en_in, pos_y_in, pos_x_in};

  // Position updates land in the pending slot and only reach the active copy at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      act        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (wr_pos && !frame_start) begin
        pend       <= pos_in;
        pend_valid <= 1'b1;
      end
      if (frame_start) begin
        pend_valid <= 1'b0;
        if (wr_pos)          act <= pos_in;
        else if (pend_valid) act <= pend;
      end
    end
  end

  logic [COORD_W:0] dx, dy;
  logic             in_box;

  // The extra MSB turns "scan left of / above the sprite" into a sign bit, so no wrap-around.
  assign dx       = {1'b0, x} - {1'b0, act.x};
  assign dy       = {1'b0, y} - {1'b0, act.y};
  assign in_box   = !dx[COORD_W] && !dy[COORD_W] && (dx < SIDE) && (dy < SIDE);
  assign lut_addr = {dy[SPR_BITS-1:0], dx[SPR_BITS-1:0]};

  logic                  hit_d1;
  logic [DATA_WIDTH-1:0] bg_d1;
  logic                  lut_hit;

  assign lut_hit = hit_d1 && (lut_data != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_d1     <= 1'b0;
      bg_d1      <= '0;
      sprite_hit <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hit_d1     <= in_box && act.en;
      bg_d1      <= bg_rgb;
      sprite_hit <= lut_hit;
      rgb_out    <= lut_hit ? lut_data : bg_d1;
    end
  end

endmodule

// File: tb/tb_crosshair_sprite_gen.sv
// Bench for crosshair_sprite_gen: behavioural LUT RAM, position model and an output scoreboard.
module tb_crosshair_sprite_gen;

  logic        clk = 0;
  logic        reset = 1;
  logic [10:0] x = 0, y = 0, pos_x_in = 0, pos_y_in = 0;
  logic [11:0] bg_rgb = 0, lut_data, rgb_out;
  logic        frame_start = 0, wr_pos = 0, en_in = 0, sprite_hit;
  logic [9:0]  lut_addr;

  crosshair_sprite_gen dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .bg_rgb(bg_rgb),
    .frame_start(frame_start), .wr_pos(wr_pos), .pos_x_in(pos_x_in),
    .pos_y_in(pos_y_in), .en_in(en_in), .lut_addr(lut_addr),
    .lut_data(lut_data), .rgb_out(rgb_out), .sprite_hit(sprite_hit)
  );

  always #5 clk = ~clk;

  logic [11:0] lut_mem [1024];
  always @(posedge clk) lut_data <= lut_mem[lut_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hit;
  } exp_t;
  exp_t q[$];

  // position model
  logic [10:0] m_ax = 0, m_ay = 0, p_x = 0, p_y = 0;
  logic        m_en = 0, p_en = 0, p_v = 0;

  function automatic void calc(input logic [10:0] xx, input logic [10:0] yy,
                               output logic h, output logic [9:0] a);
    int dx, dy;
    dx = int'(xx) - int'(m_ax);
    dy = int'(yy) - int'(m_ay);
    h  = m_en && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
    a  = 10'(((dy & 31) << 5) | (dx & 31));
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks += 2;
      if (rgb_out !== e.rgb) begin
        errors++;
        $display("FAIL rgb_out cyc=%0d got=%h want=%h", cyc, rgb_out, e.rgb);
      end
      if (sprite_hit !== e.hit) begin
        errors++;
        $display("FAIL sprite_hit cyc=%0d got=%b want=%b", cyc, sprite_hit, e.hit);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, input logic fs, input logic wr,
                       input logic [10:0] xx, input logic [10:0] yy, input logic [11:0] bg,
                       input logic [10:0] px, input logic [10:0] py, input logic pe);
    logic       h;
    logic [9:0] a;
    exp_t       e;
    reset = r; frame_start = fs; wr_pos = wr; x = xx; y = yy; bg_rgb = bg;
    pos_x_in = px; pos_y_in = py; en_in = pe;
    if (r) begin
      q.delete();
      m_ax = 0; m_ay = 0; m_en = 0; p_x = 0; p_y = 0; p_en = 0; p_v = 0;
    end else begin
      calc(xx, yy, h, a);
      e.due = cyc + 2;
      e.hit = h && (lut_mem[a] != 12'h000);
      e.rgb = e.hit ? lut_mem[a] : bg;
      q.push_back(e);
      if (fs && wr) begin
        m_ax = px; m_ay = py; m_en = pe; p_v = 0;
      end else if (fs) begin
        if (p_v) begin m_ax = p_x; m_ay = p_y; m_en = p_en; end
        p_v = 0;
      end else if (wr) begin
        p_x = px; p_y = py; p_en = pe; p_v = 1;
      end
    end
    #1;
  endtask

  task automatic pix(input logic [10:0] xx, input logic [10:0] yy);
    drive(0, 0, 0, xx, yy, 12'($urandom), 0, 0, 0); tick();
  endtask

  task automatic setpos(input logic fs, input logic [10:0] px, input logic [10:0] py, input logic pe);
    drive(0, fs, 1, 0, 0, 12'($urandom), px, py, pe); tick();
  endtask

  task automatic commit();
    drive(0, 1, 0, 0, 0, 12'($urandom), 0, 0, 0); tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 12'hABC, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 12'hABC, 0, 0, 0); tick();
    checks += 3;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h want=000", rgb_out); end
    if (sprite_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", sprite_hit); end
    if (lut_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", lut_addr); end
  endtask

  task automatic test_hit_addr();
    setpos(0, 100, 50, 1);
    commit();
    drive(0, 0, 0, 100, 50, 12'h123, 0, 0, 0);
    checks++;
    if (lut_addr !== 10'd0) begin errors++; $display("FAIL addr_origin got=%0d want=0", lut_addr); end
    tick();
    drive(0, 0, 0, 131, 81, 12'h456, 0, 0, 0);
    checks++;
    if (lut_addr !== 10'd1023) begin errors++; $display("FAIL addr_corner got=%0d want=1023", lut_addr); end
    tick();
    drive(0, 0, 0, 110, 53, 12'h789, 0, 0, 0);
    checks++;
    if (lut_addr !== 10'd106) begin errors++; $display("FAIL addr_mid got=%0d want=106", lut_addr); end
    tick();
    for (int i = 96; i < 136; i++) pix(11'(i), 60);
  endtask

  task automatic test_outside();
    pix(99, 50); pix(132, 50); pix(100, 49); pix(100, 82); pix(131, 82); pix(132, 81);
  endtask

  task automatic test_chroma();
    pix(104, 50);
    drive(0, 0, 0, 105, 50, 12'hF00, 0, 0, 0); tick();
    pix(0, 0);
    checks += 2;
    if (rgb_out !== 12'h00F) begin errors++; $display("FAIL chroma_rgb got=%h want=00F", rgb_out); end
    if (sprite_hit !== 1'b1) begin errors++; $display("FAIL chroma_hit got=%b want=1", sprite_hit); end
  endtask

  task automatic test_double_buffer();
    setpos(0, 200, 200, 1);
    pix(100, 50); pix(200, 200); pix(131, 81);
    setpos(1, 300, 10, 1);
    drive(0, 0, 0, 300, 10, 12'h321, 0, 0, 0);
    checks++;
    if (lut_addr !== 10'd0) begin errors++; $display("FAIL addr_fs_wr got=%0d want=0", lut_addr); end
    tick();
    pix(100, 50); pix(331, 41);
    setpos(0, 1, 1, 1); setpos(0, 120, 60, 1);
    pix(120, 60);
    commit();
    pix(120, 60); pix(1, 1);
    commit();
    pix(121, 61); pix(151, 91);
  endtask

  task automatic test_no_wrap();
    setpos(1, 2040, 470, 1);
    drive(0, 0, 0, 2047, 470, 12'h0AA, 0, 0, 0);
    checks++;
    if (lut_addr !== 10'd7) begin errors++; $display("FAIL addr_edge got=%0d want=7", lut_addr); end
    tick();
    pix(0, 470); pix(2047, 501); pix(6, 471);
  endtask

  task automatic test_reset_mid();
    pix(2047, 470);
    drive(1, 0, 0, 2047, 470, 12'h0AA, 0, 0, 0); tick();
    checks += 2;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL midreset_rgb got=%h want=000", rgb_out); end
    if (sprite_hit !== 1'b0) begin errors++; $display("FAIL midreset_hit got=%b want=0", sprite_hit); end
    drive(0, 0, 0, 3, 2, 12'h555, 0, 0, 0);
    checks++;
    if (lut_addr !== 10'd67) begin errors++; $display("FAIL midreset_addr got=%0d want=67", lut_addr); end
    tick();
    pix(5, 5);
    setpos(0, 0, 0, 1);
    pix(3, 2);
    commit();
    pix(3, 2); pix(0, 0);
    checks++;
    if (sprite_hit !== 1'b1) begin errors++; $display("FAIL recommit_hit got=%b want=1", sprite_hit); end
  endtask

  task automatic test_back_to_back();
    setpos(1, 100, 50, 1);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      drive(0, r == 0 || r == 1, r == 1 || r == 2,
            11'($urandom_range(90, 145)), 11'($urandom_range(40, 95)), 12'($urandom),
            11'($urandom_range(90, 115)), 11'($urandom_range(40, 65)), r != 2 || ($urandom_range(0, 3) != 0));
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] ai;
      ai = i[9:0];
      lut_mem[i] = (i % 13 == 4) ? 12'h000 : {ai, 2'b01};
    end
    lut_mem[5] = 12'h00F;
    @(posedge clk); #1;
    test_reset();
    test_hit_addr();
    test_outside();
    test_chroma();
    test_double_buffer();
    test_no_wrap();
    test_reset_mid();
    test_back_to_back();
    repeat (4) tick();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain got=%0d want=0 pending", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
